// File: rtl/lke_pkg.sv
// Shared types and defaults for the lookup-engine update scheduler.
// Holds the scheduler state encoding and the default table geometry.
package lke_pkg;

    localparam int LKE_KEY_LEN = 197;
    localparam int LKE_ACT_LEN = 625;
    localparam int LKE_ADDR_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } lke_state_t;

    // Ceiling log2, never below 1 so it can size a counter directly.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lke_inflight_cnt.sv
// Occupancy counter for lookups in flight between key acceptance and action retire.
// Saturates at both ends; simultaneous accept and retire leave it unchanged.
module lke_inflight_cnt
    import lke_pkg::*;
#(
    parameter int MAX_CNT = 7,
    localparam int CNT_W = clog2(MAX_CNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    input  logic             retire,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CNT);

    function automatic logic [CNT_W-1:0] sat_step(
        input logic [CNT_W-1:0] cur,
        input logic             up,
        input logic             dn
    );
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (up && !dn && (cur != CNT_MAX))
            nxt = cur + CNT_W'(1);
        else if (dn && !up && (cur != '0))
            nxt = cur - CNT_W'(1);
        return nxt;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= sat_step(cnt, accept, retire);
    end

    // A retire with nothing in flight points at a lookup-engine protocol bug.
    underflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(retire && !accept && (cnt == '0)));

endmodule

// File: rtl/lke_update_sched.sv
// Update scheduler: stalls lookups, drains the engine, issues one CAM or action-RAM
// write, holds for a settle window, then reopens the key gate.
module lke_update_sched
    import lke_pkg::*;
#(
    parameter int KEY_LEN      = LKE_KEY_LEN,
    parameter int ACT_LEN      = LKE_ACT_LEN,
    parameter int ADDR_W       = LKE_ADDR_W,
    parameter int MAX_INFLIGHT = 7,
    parameter int SETTLE_CYC   = 2,
    parameter int GAP_CYC      = 4,
    localparam int CNT_W = clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid_in,
    output logic               key_ready_out,
    output logic               key_valid_out,
    input  logic               lke_ready_in,
    input  logic               act_valid_in,
    input  logic               act_ready_in,
    input  logic               wr_req,
    input  logic               wr_sel_cam,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [KEY_LEN-1:0] wr_key,
    input  logic [ACT_LEN-1:0] wr_act,
    output logic               cam_we,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  tbl_addr,
    output logic [KEY_LEN-1:0] cam_wdata,
    output logic [ACT_LEN-1:0] ram_wdata,
    output logic               wr_ack,
    output logic [CNT_W-1:0]   inflight,
    output logic               busy
);

    localparam int SET_W = clog2(SETTLE_CYC + 1);
    localparam int GAP_W = clog2(GAP_CYC + 1);

    lke_state_t       state;
    lke_state_t       state_nxt;
    logic             gate_open;
    logic             accept;
    logic             retire;
    logic             req_take;
    logic             hold_last;
    logic             sel_cam_p1;
    logic [SET_W-1:0] settle_cnt;
    logic [GAP_W-1:0] gap_cnt;

    assign gate_open     = (state == IDLE) && (inflight < CNT_W'(MAX_INFLIGHT));
    assign key_valid_out = key_valid_in & gate_open;
    assign key_ready_out = lke_ready_in & gate_open;
    assign accept        = key_valid_in & lke_ready_in & gate_open;
    assign retire        = act_valid_in & act_ready_in;

    lke_inflight_cnt #(
        .MAX_CNT (MAX_INFLIGHT)
    ) u_inflight_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .accept  (accept),
        .retire  (retire),
        .cnt     (inflight)
    );

    // The gap only defers a write while keys are actually waiting.
    always_comb begin
        state_nxt = state;
        req_take  = 1'b0;
        hold_last = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req && ((gap_cnt == '0) || !key_valid_in)) begin
                    req_take  = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0)
                    state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (settle_cnt <= SET_W'(1)) begin
                    hold_last = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cam_we     <= 1'b0;
            ram_we     <= 1'b0;
            wr_ack     <= 1'b0;
            settle_cnt <= '0;
            gap_cnt    <= '0;
            sel_cam_p1 <= 1'b0;
            tbl_addr   <= '0;
            cam_wdata  <= '0;
            ram_wdata  <= '0;
        end else begin
            state  <= state_nxt;
            busy   <= (state_nxt != IDLE);
            cam_we <= (state_nxt == WRITE) && sel_cam_p1;
            ram_we <= (state_nxt == WRITE) && !sel_cam_p1;
            wr_ack <= hold_last;

            if (req_take) begin
                sel_cam_p1 <= wr_sel_cam;
                tbl_addr   <= wr_addr;
                cam_wdata  <= wr_key;
                ram_wdata  <= wr_act;
            end

            if (state == WRITE)
                settle_cnt <= SET_W'(SETTLE_CYC);
            else if ((state == HOLD) && (settle_cnt != '0))
                settle_cnt <= settle_cnt - SET_W'(1);

            if (hold_last)
                gap_cnt <= GAP_W'(GAP_CYC);
            else if ((state == IDLE) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

endmodule

// File: doc/lke_update_sched.md
Name: lke_update_sched

Overview:
- Schedules table updates for the per-stage lookup engine, i.e. the CAM match part plus the action RAM part.
- Arbitrates between datapath lookups and control-path write requests:
  - stalls new key acceptance;
  - drains in-flight lookups;
  - issues exactly one CAM or action-RAM write;
  - holds for a settle window, then resumes lookups.
- Sits between the key extractor and the lookup engine, alongside the control-packet parser that raises write requests.

Parameters:
- KEY_LEN, 197, CAM entry (key) width.
- ACT_LEN, 625, action RAM entry width.
- ADDR_W, 4, table address width (16 entries).
- MAX_INFLIGHT, 7, maximum lookups in flight; sets the counter width to clog2(MAX_INFLIGHT+1).
- SETTLE_CYC, 2, cycles held after a write before lookups resume.
- GAP_CYC, 4, minimum lookup-service window between consecutive writes.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- key_valid_in, in, 1, key offered by the key extractor.
- key_ready_out, out, 1, ready returned to the key extractor.
- key_valid_out, out, 1, gated key_valid toward the lookup engine.
- lke_ready_in, in, 1, lookup engine ready_out.
- act_valid_in, in, 1, lookup engine action_valid.
- act_ready_in, in, 1, downstream ready_in (observed only).
- wr_req, in, 1, write request from the control parser; held until wr_ack.
- wr_sel_cam, in, 1, 1 = CAM write, 0 = action RAM write.
- wr_addr, in, ADDR_W, entry index.
- wr_key, in, KEY_LEN, CAM entry data.
- wr_act, in, ACT_LEN, action entry data.
- cam_we, out, 1, CAM write strobe.
- ram_we, out, 1, action RAM write strobe.
- tbl_addr, out, ADDR_W, write address.
- cam_wdata, out, KEY_LEN, registered CAM write data.
- ram_wdata, out, ACT_LEN, registered action write data.
- wr_ack, out, 1, one-cycle pulse when the update is complete.
- inflight, out, clog2(MAX_INFLIGHT+1), current occupancy (debug).
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (synchronous, rst_n=0): FSM=IDLE; inflight=0; gap counter=0; settle counter=0; all strobes, wr_ack and busy 0; address and data registers 0.
- Lookup accept: accept = key_valid_in & lke_ready_in & gate_open.
  - key_valid_out = key_valid_in & gate_open.
  - key_ready_out = lke_ready_in & gate_open.
  - gate_open = (state==IDLE) & (inflight<MAX_INFLIGHT).
- Retire: retire = act_valid_in & act_ready_in.
- inflight update: +1 on accept only; -1 on retire only; unchanged when both occur in the same cycle.
  - Retire at inflight=0 is ignored, with no underflow; a simulation assertion flags it.
- FSM states:
  - IDLE: if wr_req & (gap==0 | ~key_valid_in), latch wr_sel_cam, wr_addr, wr_key and wr_act, then go to DRAIN. Otherwise stay.
  - DRAIN: gate closed. When inflight==0, go to WRITE. If inflight is already 0 on entry, DRAIN still lasts exactly 1 cycle.
  - WRITE: one cycle. cam_we = sel_cam or ram_we = ~sel_cam, never both. tbl_addr and the write data come from the latched registers. Next state is HOLD.
  - HOLD: lasts SETTLE_CYC cycles, counting down. On the final cycle, wr_ack=1 and gap is loaded with GAP_CYC. Next state is IDLE.
- Gap counter: decrements each IDLE cycle while >0. It holds off a new write only while the datapath has traffic (key_valid_in); with no traffic, a write starts immediately. This prevents update starvation of lookups.
- Minimum write latency: wr_req rising edge to wr_ack = 1 (IDLE) + 1 (DRAIN) + 1 (WRITE) + SETTLE_CYC = 5 cycles at defaults, with an empty pipeline.
- wr_req must stay high until wr_ack. Dropping it after acceptance does not abort the update.
- A wr_req still high in the cycle after wr_ack is treated as a new request.
- Request data changes after the IDLE latch are ignored.
- Reset mid-DRAIN, WRITE or HOLD: return to IDLE, strobes drop the same cycle, no wr_ack.
- busy = (state!=IDLE).
- All outputs are registered except key_valid_out and key_ready_out, which are combinational from the registered state and inflight.

Decomposition:
- Shared package lke_pkg:
  - state enum {IDLE, DRAIN, WRITE, HOLD};
  - ADDR_W;
  - function clog2;
  - KEY_LEN and ACT_LEN defaults.
- One natural sub-module, lke_inflight_cnt: saturating up/down occupancy counter with accept and retire inputs and underflow/overflow guards.

Test Plan:
- Idle write: inflight=0, wr_req with sel_cam=1, addr=3, key=0x1AB.
  - Required: cam_we high exactly 1 cycle, 2 cycles after the request, with tbl_addr=3 and cam_wdata=0x1AB.
  - Required: wr_ack 5 cycles after the request; ram_we never asserted.
- Drain: accept 3 keys, then raise wr_req (sel_cam=0, addr=9).
  - Required: key_ready_out=0 from the next cycle.
  - Retire the 3 actions at cycles +4, +6, +8: ram_we fires the cycle after inflight reaches 0; no key accepted until wr_ack plus 1.
- Simultaneous events: accept and retire in the same cycle at inflight=2.
  - Required: inflight stays 2.
  - Fill to 7: key_ready_out=0 even when lke_ready_in=1.
- Gap fairness: two back-to-back wr_req with key_valid_in held high.
  - Required: second DRAIN entry no earlier than GAP_CYC=4 cycles after the first wr_ack.
  - Repeat with key_valid_in=0: second DRAIN entry the cycle after wr_ack.
- Reset mid-HOLD: assert rst_n=0 during HOLD.
  - Required: no wr_ack; busy=0, inflight=0 and all strobes 0 the next cycle; key_ready_out follows lke_ready_in after reset.
